// File: rtl/pipe_parity_check.sv
// Receive-side parity checker: recomputes parity of {din_par, din} through a pipelined
// 6-input XOR tree, forwards the delayed word, and flags, counts and latches mismatches.
module pipe_parity_check #(
  parameter int WIDTH   = 100,
  parameter bit ODD_PAR = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  input  logic             din_par,
  input  logic             clr,
  output logic             dout_valid,
  output logic [WIDTH-1:0] dout,
  output logic             par_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
);

  localparam int N       = WIDTH + 1;
  localparam int LATENCY = (N <= 6) ? 1 : (N <= 36) ? 2 : (N <= 216) ? 3 : 4;

  // Streaming input with no backpressure: din_valid alone qualifies a word, and every
  // sampled word leaves exactly LATENCY cycles later with dout_valid set.

  // One tree level: bit i of the input folds into bit i/6 of the result, so each
  // output bit is the XOR of a group of at most six input bits.
  function automatic logic [N-1:0] xor6(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[i/6] = r[i/6] ^ v[i];
    end
    return r;
  endfunction

  logic [N-1:0]       tree_q  [LATENCY];
  logic [WIDTH-1:0]   data_q  [LATENCY];
  logic [LATENCY-1:0] valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LATENCY; s++) begin
        tree_q[s] <= '0;
        data_q[s] <= '0;
      end
      valid_q <= '0;
    end else begin
      tree_q[0]  <= xor6({din_par, din});
      data_q[0]  <= din;
      valid_q[0] <= din_valid;
      for (int s = 1; s < LATENCY; s++) begin
        tree_q[s]  <= xor6(tree_q[s-1]);
        data_q[s]  <= data_q[s-1];
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  // Outputs come straight from the last register stage; the final level has reduced
  // the word to a single parity bit in position 0.
  assign dout_valid = valid_q[LATENCY-1];
  assign dout       = data_q[LATENCY-1];
  assign par_err    = valid_q[LATENCY-1] & (tree_q[LATENCY-1][0] ^ ODD_PAR);

  // clr takes priority over a coincident error, which is then not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (clr) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (par_err) begin
      err_sticky <= 1'b1;
      if (err_cnt != {CNT_W{1'b1}}) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_parity_check.sv
// Directed bench for pipe_parity_check at WIDTH=100 (latency 3), WIDTH=5 (latency 1)
// and WIDTH=36 (latency 3), all even parity, sharing clock, reset, valid and clear.
module tb_pipe_parity_check;

  logic        clk, rst_n, din_valid, clr;
  logic [99:0] din;
  logic        par_a, par_b, par_c;

  logic        a_valid, a_err, a_stk;
  logic [99:0] a_dout;
  logic [2:0]  a_cnt;
  logic        b_valid, b_err, b_stk;
  logic [4:0]  b_dout;
  logic [2:0]  b_cnt;
  logic        c_valid, c_err, c_stk;
  logic [35:0] c_dout;
  logic [15:0] c_cnt;

  pipe_parity_check #(.WIDTH(100), .ODD_PAR(1'b0), .CNT_W(3)) u_a (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .din_par(par_a), .clr(clr),
    .dout_valid(a_valid), .dout(a_dout), .par_err(a_err), .err_cnt(a_cnt), .err_sticky(a_stk)
  );

  pipe_parity_check #(.WIDTH(5), .ODD_PAR(1'b0), .CNT_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din[4:0]), .din_par(par_b), .clr(clr),
    .dout_valid(b_valid), .dout(b_dout), .par_err(b_err), .err_cnt(b_cnt), .err_sticky(b_stk)
  );

  pipe_parity_check #(.WIDTH(36), .ODD_PAR(1'b0), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din[35:0]), .din_par(par_c), .clr(clr),
    .dout_valid(c_valid), .dout(c_dout), .par_err(c_err), .err_cnt(c_cnt), .err_sticky(c_stk)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, limit 300000", $time);
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int passed = 0;

  // reference model: history of driven words and expected counters
  typedef struct packed {
    logic        v;
    logic [99:0] d;
    logic        bad;
  } word_t;

  word_t       hist[$];
  logic        ea_v, ea_err, eb_v, eb_err, ec_v, ec_err;
  logic [99:0] ea_d;
  logic [4:0]  eb_d;
  logic [35:0] ec_d;
  logic [2:0]  cnt_a, cnt_b;
  logic [15:0] cnt_c;
  logic        stk_a, stk_b, stk_c;

  function automatic logic [99:0] rand100();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[99:0];
  endfunction

  task automatic model_reset();
    hist.delete();
    {ea_v, ea_err, eb_v, eb_err, ec_v, ec_err} = '0;
    ea_d = '0; eb_d = '0; ec_d = '0;
    cnt_a = '0; cnt_b = '0; cnt_c = '0;
    stk_a = 1'b0; stk_b = 1'b0; stk_c = 1'b0;
  endtask

  // driver: called at a falling edge, drives one cycle, returns at the next falling edge
  // with the expected outputs for that moment. bad=1 inverts the correct parity bit.
  task automatic cycle(input logic v, input logic [99:0] d, input logic bad, input logic c);
    word_t w;
    word_t t;
    din_valid = v;
    din       = d;
    par_a     = (^d) ^ bad;
    par_b     = (^d[4:0]) ^ bad;
    par_c     = (^d[35:0]) ^ bad;
    clr       = c;
    if (c) begin
      cnt_a = '0; cnt_b = '0; cnt_c = '0;
      stk_a = 1'b0; stk_b = 1'b0; stk_c = 1'b0;
    end else begin
      if (ea_err) begin stk_a = 1'b1; if (cnt_a != 3'd7) cnt_a = cnt_a + 3'd1; end
      if (eb_err) begin stk_b = 1'b1; if (cnt_b != 3'd7) cnt_b = cnt_b + 3'd1; end
      if (ec_err) begin stk_c = 1'b1; if (cnt_c != 16'hffff) cnt_c = cnt_c + 16'd1; end
    end
    w.v = v; w.d = d; w.bad = bad;
    hist.push_front(w);
    if (hist.size() > 3) void'(hist.pop_back());
    @(posedge clk);
    @(negedge clk);
    t = hist[0];
    eb_v = t.v; eb_d = t.d[4:0]; eb_err = t.v & t.bad;
    if (hist.size() >= 3) begin
      t = hist[2];
      ea_v = t.v; ea_d = t.d; ea_err = t.v & t.bad; ec_d = t.d[35:0];
    end else begin
      ea_v = 1'b0; ea_d = '0; ea_err = 1'b0; ec_d = '0;
    end
    ec_v = ea_v; ec_err = ea_err;
  endtask

  task automatic test_reset();
    int first_a, first_b, first_c;
    logic [99:0] d;
    rst_n = 1'b0; clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = rand100();
      din_valid = 1'b1; din = d; par_a = $urandom_range(0, 1);
      par_b = $urandom_range(0, 1); par_c = $urandom_range(0, 1);
      @(posedge clk); @(negedge clk);
      checks++;
      if ({a_valid, a_err, a_cnt, a_stk, a_dout, b_valid, b_err, b_cnt, b_stk, b_dout,
           c_valid, c_err, c_cnt, c_stk, c_dout} !== '0)
        $display("FAIL reset_outputs: got a=%b/%h b=%b/%h c=%b/%h required all zero",
                 {a_valid, a_err, a_cnt, a_stk}, a_dout, {b_valid, b_err, b_cnt, b_stk}, b_dout,
                 {c_valid, c_err, c_cnt, c_stk}, c_dout);
      else passed++;
    end
    model_reset();
    rst_n = 1'b1;
    first_a = -1; first_b = -1; first_c = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(i < 10, rand100(), 1'b0, 1'b0);
      if (a_valid && first_a < 0) first_a = i + 1;
      if (b_valid && first_b < 0) first_b = i + 1;
      if (c_valid && first_c < 0) first_c = i + 1;
      checks++;
      if ({a_err, b_err, c_err} !== 3'b000)
        $display("FAIL release_par_err: got a=%b b=%b c=%b required 0", a_err, b_err, c_err);
      else passed++;
      if (!ea_v) begin
        checks++;
        if (a_dout !== '0) $display("FAIL release_dout_zero: got %h required 0", a_dout);
        else passed++;
      end
    end
    checks++;
    if (first_a !== 3) $display("FAIL latency_a: got %0d required 3", first_a); else passed++;
    checks++;
    if (first_b !== 1) $display("FAIL latency_b: got %0d required 1", first_b); else passed++;
    checks++;
    if (first_c !== 3) $display("FAIL latency_c: got %0d required 3", first_c); else passed++;
  endtask

  task automatic test_good_stream();
    for (int i = 0; i < 1004; i++) begin
      cycle(i < 1000, rand100(), 1'b0, 1'b0);
      checks++;
      if ({a_valid, a_err, a_cnt, a_stk} !== {ea_v, 1'b0, 3'd0, 1'b0})
        $display("FAIL good_ctl_a: got %b required %b", {a_valid, a_err, a_cnt, a_stk}, {ea_v, 5'd0});
      else passed++;
      checks++;
      if ({b_valid, b_err, b_cnt, b_stk} !== {eb_v, 1'b0, 3'd0, 1'b0})
        $display("FAIL good_ctl_b: got %b required %b", {b_valid, b_err, b_cnt, b_stk}, {eb_v, 5'd0});
      else passed++;
      checks++;
      if ({c_valid, c_err, c_cnt, c_stk} !== {ec_v, 18'd0})
        $display("FAIL good_ctl_c: got %b/%0d required %b/0", {c_valid, c_err, c_stk}, c_cnt, ec_v);
      else passed++;
      if (ea_v) begin
        checks++;
        if (a_dout !== ea_d) $display("FAIL good_dout_a: got %h required %h", a_dout, ea_d);
        else passed++;
        checks++;
        if (c_dout !== ec_d) $display("FAIL good_dout_c: got %h required %h", c_dout, ec_d);
        else passed++;
      end
      if (eb_v) begin
        checks++;
        if (b_dout !== eb_d) $display("FAIL good_dout_b: got %h required %h", b_dout, eb_d);
        else passed++;
      end
    end
  endtask

  task automatic test_single_bit();
    logic [99:0] one;
    int hit_a, hit_b;
    one = 100'h1;
    cycle(1'b0, '0, 1'b0, 1'b1);
    // ^one is 1, so bad=1 sends din_par=0: a mismatch for all three widths
    cycle(1'b1, one, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      hit_a = (i >= 4) ? 1 : 0;
      hit_b = (i >= 2) ? 1 : 0;
      checks++;
      if ({a_err, a_cnt, a_stk, c_err} !== {1'(i == 3), 3'(hit_a), 1'(hit_a), 1'(i == 3)})
        $display("FAIL single_err_a step%0d: got err=%b cnt=%0d stk=%b c_err=%b required err=%b cnt=%0d",
                 i, a_err, a_cnt, a_stk, c_err, (i == 3), hit_a);
      else passed++;
      checks++;
      if ({b_err, b_cnt, b_stk} !== {1'(i == 1), 3'(hit_b), 1'(hit_b)})
        $display("FAIL single_err_b step%0d: got err=%b cnt=%0d stk=%b required err=%b cnt=%0d",
                 i, b_err, b_cnt, b_stk, (i == 1), hit_b);
      else passed++;
      cycle(1'b0, '0, 1'b0, 1'b0);
    end
    cycle(1'b1, one, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if ({a_err, a_cnt, a_stk, b_err, b_cnt, b_stk} !== {1'b0, 3'd1, 1'b1, 1'b0, 3'd1, 1'b1})
        $display("FAIL single_good step%0d: got a=%b/%0d b=%b/%0d required 0/1 0/1",
                 i, a_err, a_cnt, b_err, b_cnt);
      else passed++;
      cycle(1'b0, '0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_valid_gaps();
    logic [2:0] start_a, start_b;
    logic [3:0] pat;
    start_a = a_cnt; start_b = b_cnt;
    pat = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) cycle(pat[3-i], rand100(), ~pat[3-i], 1'b0);
      else cycle(1'b0, rand100(), 1'b1, 1'b0);
      checks++;
      if ({a_err, b_err, c_err, a_cnt, b_cnt} !== {3'b000, start_a, start_b})
        $display("FAIL gaps_err step%0d: got err=%b%b%b cnt=%0d/%0d required 000 cnt=%0d/%0d",
                 i, a_err, b_err, c_err, a_cnt, b_cnt, start_a, start_b);
      else passed++;
      checks++;
      if ({a_valid, b_valid, c_valid} !== {ea_v, eb_v, ec_v})
        $display("FAIL gaps_valid step%0d: got %b required %b", i, {a_valid, b_valid, c_valid},
                 {ea_v, eb_v, ec_v});
      else passed++;
      if (ea_v) begin
        checks++;
        if (a_dout !== ea_d) $display("FAIL gaps_dout_a: got %h required %h", a_dout, ea_d);
        else passed++;
      end
    end
  endtask

  task automatic test_saturation();
    int ka, kb;
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 13; i++) begin
      cycle(i <= 9, rand100(), i <= 9, 1'b0);
      ka = (i > 3) ? i - 3 : 0; if (ka > 7) ka = 7;
      kb = i - 1; if (kb > 7) kb = 7;
      checks++;
      if ({a_err, a_cnt} !== {1'(i >= 3 && i <= 11), 3'(ka)})
        $display("FAIL sat_a step%0d: got err=%b cnt=%0d required err=%b cnt=%0d",
                 i, a_err, a_cnt, (i >= 3 && i <= 11), ka);
      else passed++;
      checks++;
      if ({b_err, b_cnt} !== {1'(i <= 9), 3'(kb)})
        $display("FAIL sat_b step%0d: got err=%b cnt=%0d required err=%b cnt=%0d",
                 i, b_err, b_cnt, (i <= 9), kb);
      else passed++;
    end
    cycle(1'b1, rand100(), 1'b1, 1'b0);
    checks++;
    if ({b_err, b_cnt, b_stk} !== {1'b1, 3'd7, 1'b1})
      $display("FAIL clr_pre_b: got err=%b cnt=%0d stk=%b required 1/7/1", b_err, b_cnt, b_stk);
    else passed++;
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if ({b_cnt, b_stk} !== 4'b0000)
      $display("FAIL clr_win_b: got cnt=%0d stk=%b required 0/0", b_cnt, b_stk);
    else passed++;
    cycle(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if ({a_err, a_cnt} !== 4'b1000)
      $display("FAIL clr_pre_a: got err=%b cnt=%0d required 1/0", a_err, a_cnt);
    else passed++;
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if ({a_cnt, a_stk} !== 4'b0000)
      $display("FAIL clr_win_a: got cnt=%0d stk=%b required 0/0", a_cnt, a_stk);
    else passed++;
  endtask

  task automatic test_mid_reset();
    cycle(1'b1, rand100(), 1'b1, 1'b0);
    checks++;
    if (b_err !== 1'b1) $display("FAIL midrst_pre_err_b: got %b required 1", b_err);
    else passed++;
    cycle(1'b1, rand100(), 1'b0, 1'b0);
    checks++;
    if ({b_cnt, b_stk} !== {3'd1, 1'b1})
      $display("FAIL midrst_pre_cnt_b: got cnt=%0d stk=%b required 1/1", b_cnt, b_stk);
    else passed++;
    din_valid = 1'b1; din = rand100();
    par_a = ~(^din); par_b = ~(^din[4:0]); par_c = ~(^din[35:0]);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_valid, a_err, a_cnt, a_stk, b_valid, b_err, b_cnt, b_stk, c_valid, c_err, c_cnt, c_stk} !== '0)
      $display("FAIL midrst_async: got a=%b b=%b c=%b required all zero",
               {a_valid, a_err, a_cnt, a_stk}, {b_valid, b_err, b_cnt, b_stk}, {c_valid, c_err, c_stk});
    else passed++;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if ({a_valid, a_err, a_cnt, b_valid, b_err, b_cnt, c_valid, c_err, c_cnt} !== '0)
        $display("FAIL midrst_flush step%0d: got a=%b/%0d b=%b/%0d c=%b/%0d required zero",
                 i, {a_valid, a_err}, a_cnt, {b_valid, b_err}, b_cnt, {c_valid, c_err}, c_cnt);
      else passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0; din_valid = 1'b0; din = '0; clr = 1'b0;
    par_a = 1'b0; par_b = 1'b0; par_c = 1'b0;
    model_reset();
    test_reset();
    test_good_stream();
    test_single_bit();
    test_valid_gaps();
    test_saturation();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
